spi_frame_packer: RTL

- Upstream stage of fifo_spi.
- Packs a stream of 32-bit samples into fixed-length frames: header (sync + sequence number), N payload words, then a 32-bit additive checksum.
- Writes each frame word into fifo_spi through its we/din port.
- Holds off frame starts while the MCU asserts its busy line, and stalls on FIFO full.

---
 rtl/spi_frame_pkg.sv | 15 +
 rtl/sync_2ff.sv | 29 ++
 rtl/spi_frame_packer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/spi_frame_pkg.sv
// Shared types and constants for the SPI frame packer.
package spi_frame_pkg;

    localparam int          WORD_W               = 32;
    localparam logic [15:0] DEFAULT_SYNC_PATTERN = 16'hA5A5;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        TSTAMP,
        PAYLOAD,
        CHECKSUM
    } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level, with a configurable
// reset value so the synchronised level starts in a known safe state.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            // NOTE: non-blocking assignments make both flops sample together,
            // giving a genuine two-stage chain rather than one merged flop.
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/spi_frame_packer.sv
// Packs 32-bit samples into header/payload/checksum frames for fifo_spi.
// Define SPI_FRAME_TSTAMP_EN to insert a cycle-counter timestamp word after the header.
module spi_frame_packer
    import spi_frame_pkg::*;
#(
    parameter int          PAYLOAD_WORDS = 16,
    parameter logic [15:0] SYNC_PATTERN  = DEFAULT_SYNC_PATTERN,
    parameter int          SEQ_WIDTH     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_valid,
    input  logic [WORD_W-1:0]    s_data,
    output logic                 s_ready,
    input  logic                 host_busy,
    input  logic                 fifo_full,
    output logic                 fifo_we,
    output logic [WORD_W-1:0]    fifo_din,
    output logic                 frame_done,
    output logic [SEQ_WIDTH-1:0] seq_num
);

    localparam logic [7:0] LAST_CNT = 8'(PAYLOAD_WORDS - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_fifo_we;
    logic                 w_fifo_we_nxt;
    logic [WORD_W-1:0]    r_fifo_din;
    logic [WORD_W-1:0]    w_fifo_din_nxt;
    logic                 r_frame_done;
    logic                 w_frame_done_nxt;
    logic [SEQ_WIDTH-1:0] r_seq;
    logic [SEQ_WIDTH-1:0] w_seq_nxt;
    logic [WORD_W-1:0]    r_csum;
    logic [WORD_W-1:0]    w_csum_nxt;
    logic [7:0]           r_cnt;
    logic [7:0]           w_cnt_nxt;
    logic                 w_busy_s;
    logic [15:0]          w_seq_ext;
    logic [WORD_W-1:0]    w_header;

`ifdef SPI_FRAME_TSTAMP_EN
    logic [WORD_W-1:0]    r_cycle_cnt;
    logic [WORD_W-1:0]    r_tstamp;
    logic [WORD_W-1:0]    w_tstamp_nxt;
`endif

    // Busy resets high so no frame can start before host_busy is seen low.
    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_busy_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (host_busy),
        .o_q   (w_busy_s)
    );

    always_comb begin
        w_seq_ext                = '0;
        w_seq_ext[SEQ_WIDTH-1:0] = r_seq;
        w_header                 = {SYNC_PATTERN, w_seq_ext};
    end

    always_comb begin
        // NOTE: every output of this block gets a default before the case,
        // so no path leaves a signal unassigned and no latch is inferred.
        w_state_nxt      = r_state;
        w_fifo_we_nxt    = 1'b0;
        w_fifo_din_nxt   = r_fifo_din;
        w_frame_done_nxt = 1'b0;
        w_seq_nxt        = r_seq;
        w_csum_nxt       = r_csum;
        w_cnt_nxt        = r_cnt;
        s_ready          = 1'b0;
`ifdef SPI_FRAME_TSTAMP_EN
        w_tstamp_nxt     = r_tstamp;
`endif

        case (r_state)
            IDLE: begin
                if (s_valid && !w_busy_s && !fifo_full) begin
                    w_state_nxt = HEADER;
                end
            end
            HEADER: begin
                if (!fifo_full) begin
                    w_fifo_we_nxt  = 1'b1;
                    w_fifo_din_nxt = w_header;
                    w_csum_nxt     = w_header;
                    w_cnt_nxt      = '0;
`ifdef SPI_FRAME_TSTAMP_EN
                    w_tstamp_nxt   = r_cycle_cnt;
                    w_state_nxt    = TSTAMP;
`else
                    w_state_nxt    = PAYLOAD;
`endif
                end
            end
`ifdef SPI_FRAME_TSTAMP_EN
            TSTAMP: begin
                if (!fifo_full) begin
                    w_fifo_we_nxt  = 1'b1;
                    w_fifo_din_nxt = r_tstamp;
                    w_csum_nxt     = r_csum + r_tstamp;
                    w_state_nxt    = PAYLOAD;
                end
            end
`endif
            PAYLOAD: begin
                // Low while full so the upstream source holds its sample.
                s_ready = !fifo_full;
                if (s_valid && !fifo_full) begin
                    w_fifo_we_nxt  = 1'b1;
                    w_fifo_din_nxt = s_data;
                    w_csum_nxt     = r_csum + s_data;
                    w_cnt_nxt      = r_cnt + 8'd1;
                    if (r_cnt == LAST_CNT) begin
                        w_state_nxt = CHECKSUM;
                    end
                end
            end
            CHECKSUM: begin
                if (!fifo_full) begin
                    w_fifo_we_nxt    = 1'b1;
                    w_fifo_din_nxt   = r_csum;
                    w_frame_done_nxt = 1'b1;
                    w_seq_nxt        = r_seq + SEQ_WIDTH'(1);
                    w_state_nxt      = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_fifo_we    <= 1'b0;
            r_fifo_din   <= '0;
            r_frame_done <= 1'b0;
            r_seq        <= '0;
            r_csum       <= '0;
            r_cnt        <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_fifo_we    <= w_fifo_we_nxt;
            r_fifo_din   <= w_fifo_din_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_seq        <= w_seq_nxt;
            r_csum       <= w_csum_nxt;
            r_cnt        <= w_cnt_nxt;
        end
    end

`ifdef SPI_FRAME_TSTAMP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle_cnt <= '0;
            r_tstamp    <= '0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
            r_tstamp    <= w_tstamp_nxt;
        end
    end
`endif

    assign fifo_we    = r_fifo_we;
    assign fifo_din   = r_fifo_din;
    assign frame_done = r_frame_done;
    assign seq_num    = r_seq;

endmodule
